// File: rtl/phase_meas_sched.sv
// phase_meas_sched
// ----------------
// Schedules measurements on a single shared phase detector for N_REQ
// requesters, each owning one clock-pair channel. Requesters are served
// round-robin. For each winner the detector input mux is switched, the
// detector is held in reset for SETTLE_CYC cycles, and then 2^AVG_LOG2
// detector samples are averaged. Each sample is guarded by a timeout of
// TIMEOUT_CYC cycles. The result is returned over a valid/ready handshake,
// tagged with the requester id.
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_req          level request per channel, held until granted
//   o_gnt          one-hot, one-cycle grant pulse
//   o_sel          channel select to the detector clock-pair mux
//   o_det_rstn     active-low detector reset (0 = detector held idle)
//   i_det_out      detector phase result
//   i_det_valid    detector sample strobe
//   o_res          averaged phase result (0 on timeout)
//   o_res_id       channel the result belongs to
//   o_res_timeout  measurement aborted by timeout
//   o_res_valid    result valid
//   i_res_ready    consumer accepts result
//   o_busy         a measurement is in progress or awaiting acceptance
module phase_meas_sched #(
    parameter int N_REQ       = 4,
    parameter int DW          = 10,
    parameter int AVG_LOG2    = 2,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_sel,
    output logic                     o_det_rstn,
    input  logic [DW-1:0]            i_det_out,
    input  logic                     i_det_valid,
    output logic [DW-1:0]            o_res,
    output logic [$clog2(N_REQ)-1:0] o_res_id,
    output logic                     o_res_timeout,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic                     o_busy
);

    localparam int SEL_W = $clog2(N_REQ);
    // The accumulator is wide enough to hold 2^AVG_LOG2 full-scale samples,
    // so the running sum never wraps.
    localparam int ACC_W = DW + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE_CYC) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   sample_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [SEL_W-1:0]   winner;
    logic               found;
    logic [N_REQ-1:0]   win_onehot;
    logic [SEL_W-1:0]   ptr_next;
    logic [ACC_W-1:0]   acc_sum;
    logic [DW-1:0]      acc_avg;

    // Round-robin search: the first requesting channel at or after the
    // pointer, wrapping past the top channel back to channel 0. The index
    // is wrapped by subtraction so non-power-of-two N_REQ works too.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && i_req[idx]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

    assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
    assign ptr_next   = (winner == SEL_W'(SEL_LAST)) ? '0 : winner + 1'b1;

    // Sum including the sample arriving this cycle; the average is the top
    // DW bits, i.e. a truncating divide by 2^AVG_LOG2.
    assign acc_sum = acc + ACC_W'(i_det_out);
    assign acc_avg = acc_sum[ACC_W-1:AVG_LOG2];

    // Scheduler FSM. All outputs are registered here. o_sel and o_res_id
    // only change at grant, so the mux stays parked on the last channel
    // between measurements. o_gnt defaults low every cycle, which makes the
    // grant a single-cycle pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_IDLE;
            ptr           <= '0;
            acc           <= '0;
            sample_cnt    <= '0;
            settle_cnt    <= '0;
            tmo_cnt       <= '0;
            o_gnt         <= '0;
            o_sel         <= '0;
            o_det_rstn    <= 1'b0;
            o_res         <= '0;
            o_res_id      <= '0;
            o_res_timeout <= 1'b0;
            o_res_valid   <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_gnt <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        o_gnt      <= win_onehot;
                        o_sel      <= winner;
                        o_res_id   <= winner;
                        ptr        <= ptr_next;
                        acc        <= '0;
                        sample_cnt <= '0;
                        settle_cnt <= '0;
                        o_det_rstn <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= S_SETTLE;
                    end
                end

                // The detector is kept in reset while the freshly switched
                // clock pair settles; any strobes it produces are ignored.
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        o_det_rstn <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= S_WAIT;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                // Every sample restarts the timeout window. A timeout drops
                // whatever has been accumulated and reports a zero result.
                S_WAIT: begin
                    if (i_det_valid) begin
                        tmo_cnt <= '0;
                        if (sample_cnt == CNT_LAST) begin
                            o_res         <= acc_avg;
                            o_res_timeout <= 1'b0;
                            o_res_valid   <= 1'b1;
                            o_det_rstn    <= 1'b0;
                            state         <= S_DONE;
                        end else begin
                            acc        <= acc_sum;
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_res         <= '0;
                        o_res_timeout <= 1'b1;
                        o_res_valid   <= 1'b1;
                        o_det_rstn    <= 1'b0;
                        state         <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                // Result is held until accepted. Returning to IDLE rather than
                // arbitrating here guarantees an idle cycle between jobs.
                S_DONE: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_meas_sched.sv
// tb_phase_meas_sched
// -------------------
// Directed self-checking bench for phase_meas_sched with default parameters
// (N_REQ=4, DW=10, AVG_LOG2=2, SETTLE_CYC=8, TIMEOUT_CYC=1024). Inputs are
// driven and outputs sampled 1 ns after the rising clock edge.
module tb_phase_meas_sched;

    localparam int N_REQ = 4;
    localparam int DW    = 10;

    logic             i_clk;
    logic             i_rst;
    logic [N_REQ-1:0] i_req;
    logic [N_REQ-1:0] o_gnt;
    logic [1:0]       o_sel;
    logic             o_det_rstn;
    logic [DW-1:0]    i_det_out;
    logic             i_det_valid;
    logic [DW-1:0]    o_res;
    logic [1:0]       o_res_id;
    logic             o_res_timeout;
    logic             o_res_valid;
    logic             i_res_ready;
    logic             o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    phase_meas_sched #(
        .N_REQ      (4),
        .DW         (10),
        .AVG_LOG2   (2),
        .SETTLE_CYC (8),
        .TIMEOUT_CYC(1024)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .o_gnt        (o_gnt),
        .o_sel        (o_sel),
        .o_det_rstn   (o_det_rstn),
        .i_det_out    (i_det_out),
        .i_det_valid  (i_det_valid),
        .o_res        (o_res),
        .o_res_id     (o_res_id),
        .o_res_timeout(o_res_timeout),
        .o_res_valid  (o_res_valid),
        .i_res_ready  (i_res_ready),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_req       = '0;
        i_det_valid = 1'b0;
        i_det_out   = '0;
        i_res_ready = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    // Drive n consecutive detector strobes carrying value v.
    task automatic feed(input logic [DW-1:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            i_det_valid = 1'b1;
            i_det_out   = v;
            tick();
        end
        i_det_valid = 1'b0;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_gnt != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rstn(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_det_rstn === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        i_rst       = 1'b1;
        i_req       = '0;
        i_det_valid = 1'b0;
        i_det_out   = '0;
        i_res_ready = 1'b0;
        #2;
        n_checks++;
        if ({o_gnt, o_sel, o_det_rstn, o_res, o_res_id, o_res_timeout, o_res_valid, o_busy} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got gnt=%b sel=%0d rstn=%b res=%0d id=%0d to=%b v=%b busy=%b required all 0",
                     o_gnt, o_sel, o_det_rstn, o_res, o_res_id, o_res_timeout, o_res_valid, o_busy);
        end
        i_req = 4'b1111;
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++;
        if (o_gnt !== '0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_held: got gnt=%b busy=%b required 0000 0", o_gnt, o_busy);
        end
        i_req = '0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_single();
        bit bad;
        i_req = 4'b0010;
        n_checks++;
        if (o_gnt !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL single_early_gnt: got %b required 0000", o_gnt);
        end
        tick();
        n_checks++;
        if (o_gnt !== 4'b0010 || o_sel !== 2'd1 || o_res_id !== 2'd1 || o_busy !== 1'b1 || o_det_rstn !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_grant: got gnt=%b sel=%0d id=%0d busy=%b rstn=%b required 0010 1 1 1 0",
                     o_gnt, o_sel, o_res_id, o_busy, o_det_rstn);
        end
        i_req = '0;
        tick();
        n_checks++;
        if (o_gnt !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL single_gnt_pulse: got %b required 0000", o_gnt);
        end
        bad = (o_det_rstn !== 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (o_det_rstn !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("[TB] FAIL single_settle_low: got rstn high early required low for 8 cycles");
        end
        tick();
        n_checks++;
        if (o_det_rstn !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_settle_end: got rstn=%b required 1", o_det_rstn);
        end
        feed(10'd100, 1);
        feed(10'd101, 1);
        feed(10'd102, 1);
        feed(10'd103, 1);
        n_checks++;
        if (o_res_valid !== 1'b1 || o_res !== 10'd101 || o_res_id !== 2'd1 || o_res_timeout !== 1'b0 || o_det_rstn !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_result: got v=%b res=%0d id=%0d to=%b rstn=%b required 1 101 1 0 0",
                     o_res_valid, o_res, o_res_id, o_res_timeout, o_det_rstn);
        end
        repeat (3) tick();
        n_checks++;
        if (o_res_valid !== 1'b1 || o_res !== 10'd101) begin
            n_fail++;
            $display("[TB] FAIL single_hold: got v=%b res=%0d required 1 101", o_res_valid, o_res);
        end
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        n_checks++;
        if (o_res_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_accept: got v=%b busy=%b required 0 0", o_res_valid, o_busy);
        end
    endtask

    task automatic test_round_robin();
        int order [6];
        bit ok;
        logic [N_REQ-1:0] exp_gnt;
        order = '{0, 1, 2, 3, 0, 3};
        do_reset();
        i_res_ready = 1'b1;
        i_req       = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            if (g == 4) i_req = 4'b1001;
            exp_gnt = '0;
            exp_gnt[order[g]] = 1'b1;
            wait_gnt(ok);
            n_checks++;
            if (!ok || o_gnt !== exp_gnt) begin
                n_fail++;
                $display("[TB] FAIL rr_grant_%0d: got %b required %b", g, o_gnt, exp_gnt);
            end
            i_req[order[g]] = 1'b0;
            wait_rstn(ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL rr_settle_%0d: got rstn=%b required 1 within 20 cycles", g, o_det_rstn);
            end
            feed(10'd40, 4);
        end
        tick();
        i_res_ready = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_res !== 10'd40) begin
            n_fail++;
            $display("[TB] FAIL rr_end: got busy=%b res=%0d required 0 40", o_busy, o_res);
        end
    endtask

    task automatic test_timeout();
        i_req = 4'b0100;
        tick();
        n_checks++;
        if (o_gnt !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL tmo_grant: got %b required 0100", o_gnt);
        end
        i_req = '0;
        repeat (1031) tick();
        n_checks++;
        if (o_res_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL tmo_early: got v=%b required 0 one cycle before timeout", o_res_valid);
        end
        tick();
        n_checks++;
        if (o_res_valid !== 1'b1 || o_res_timeout !== 1'b1 || o_res !== 10'd0 || o_res_id !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL tmo_result: got v=%b to=%b res=%0d id=%0d required 1 1 0 2",
                     o_res_valid, o_res_timeout, o_res, o_res_id);
        end
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit bad;
        i_req = 4'b0001;
        tick();
        n_checks++;
        if (o_gnt !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL bp_grant: got %b required 0001", o_gnt);
        end
        i_req = '0;
        wait_rstn(ok);
        i_req = 4'b0100;
        feed(10'd1023, 4);
        n_checks++;
        if (!ok || o_res_valid !== 1'b1 || o_res !== 10'd1023 || o_res_timeout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_result: got v=%b res=%0d to=%b required 1 1023 0", o_res_valid, o_res, o_res_timeout);
        end
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_gnt !== 4'b0000 || o_res !== 10'd1023 || o_res_valid !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("[TB] FAIL bp_stall: got gnt=%b res=%0d v=%b required no grant, 1023 held", o_gnt, o_res, o_res_valid);
        end
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        n_checks++;
        if (o_res_valid !== 1'b0 || o_gnt !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL bp_accept: got v=%b gnt=%b required 0 0000", o_res_valid, o_gnt);
        end
        tick();
        n_checks++;
        if (o_gnt !== 4'b0100 || o_sel !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL bp_next_grant: got gnt=%b sel=%0d required 0100 2", o_gnt, o_sel);
        end
        i_req = '0;
    endtask

    task automatic test_ignored_strobes();
        do_reset();
        i_req = 4'b0001;
        tick();
        i_req       = '0;
        i_det_valid = 1'b1;
        i_det_out   = 10'd500;
        repeat (8) tick();
        i_det_valid = 1'b0;
        n_checks++;
        if (o_det_rstn !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ign_settle: got rstn=%b required 1", o_det_rstn);
        end
        feed(10'd20, 4);
        n_checks++;
        if (o_res_valid !== 1'b1 || o_res !== 10'd20) begin
            n_fail++;
            $display("[TB] FAIL ign_result: got v=%b res=%0d required 1 20", o_res_valid, o_res);
        end
        feed(10'd500, 2);
        n_checks++;
        if (o_res !== 10'd20 || o_res_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ign_done_strobe: got res=%0d v=%b required 20 1", o_res, o_res_valid);
        end
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        do_reset();
        i_req = 4'b0100;
        tick();
        i_req = '0;
        wait_rstn(ok);
        feed(10'd50, 2);
        #2;
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (!ok || o_det_rstn !== 1'b0 || o_busy !== 1'b0 || o_sel !== 2'd0 || o_res_id !== 2'd0 || o_res_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_async: got rstn=%b busy=%b sel=%0d id=%0d v=%b required 0 0 0 0 0",
                     o_det_rstn, o_busy, o_sel, o_res_id, o_res_valid);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        i_req = 4'b1001;
        tick();
        n_checks++;
        if (o_gnt !== 4'b0001 || o_sel !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_ptr: got gnt=%b sel=%0d required 0001 0", o_gnt, o_sel);
        end
        i_req = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_back_to_back();
        test_ignored_strobes();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_meas_sched.md
Name: phase_meas_sched

Overview:
Measurement scheduler in front of a single shared phase_detector instance. Arbitrates round-robin between N_REQ requesters, each owning one clock-pair channel. For the winner it steers the detector's input mux, holds the detector in reset for a settle window, then averages 2^AVG_LOG2 valid detector samples, applying a per-sample timeout. Returns the result with a valid/ready handshake, tagged with the requester id.

Parameters:
N_REQ, 4, number of requesters/channels (>=2)
DW, 10, detector result width
AVG_LOG2, 2, log2 of samples averaged per measurement (0..4)
SETTLE_CYC, 8, cycles the detector is held in reset after the mux switches (>=1)
TIMEOUT_CYC, 1024, max cycles to wait for each detector sample (>=2)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_req  in  N_REQ  level request per channel; held until granted
o_gnt  out  N_REQ  one-hot, one-cycle grant pulse
o_sel  out  $clog2(N_REQ)  channel select to the detector clock-pair mux
o_det_rstn  out  1  active-low detector reset (0 = hold detector idle)
i_det_out  in  DW  detector phase result
i_det_valid  in  1  detector sample strobe
o_res  out  DW  averaged phase result
o_res_id  out  $clog2(N_REQ)  channel the result belongs to
o_res_timeout  out  1  measurement aborted by timeout
o_res_valid  out  1  result valid
i_res_ready  in  1  consumer accepts result
o_busy  out  1  state != IDLE

Behaviour:
- One clock domain: i_clk. Reset is asynchronous and active-high on i_rst. All outputs are registered.
- Reset values: all outputs 0; o_det_rstn=0; state IDLE; round-robin pointer 0 (channel 0 has highest priority).
- States: IDLE, SETTLE, WAIT, DONE.
- IDLE, when i_req != 0:
  - winner = first set bit at or after the pointer, wrapping.
  - Next edge: o_gnt=onehot(winner) for exactly one cycle; o_sel=winner; o_res_id=winner; pointer=(winner+1) mod N_REQ; accumulator and sample count cleared; state -> SETTLE.
  - Grant latency is 1 cycle from i_req.
- SETTLE:
  - o_det_rstn=0 for SETTLE_CYC cycles.
  - i_det_valid is ignored.
  - Then state -> WAIT, o_det_rstn=1, timeout counter cleared.
- WAIT, on i_det_valid:
  - acc += zero-extended i_det_out; acc width is DW+AVG_LOG2, so it cannot overflow.
  - Sample count increments; timeout counter clears.
  - On the 2^AVG_LOG2-th sample: o_res = acc_final >> AVG_LOG2 (truncating, no rounding); o_res_timeout=0; state -> DONE.
- WAIT, timeout:
  - If TIMEOUT_CYC cycles elapse without i_det_valid: o_res=0, o_res_timeout=1, state -> DONE.
  - Any partial accumulation is discarded.
- DONE:
  - o_res_valid=1; o_det_rstn=0.
  - o_res, o_res_id and o_res_timeout stay stable until accepted.
  - When o_res_valid && i_res_ready at an edge: o_res_valid=0, state -> IDLE.
  - Arbitration for the next measurement happens in the following IDLE cycle, so there is a minimum one idle cycle between measurements.
- Requests arriving while busy stay pending and are arbitrated in IDLE. A requester must deassert i_req after o_gnt; if still high it is re-granted in round-robin order.
- o_sel holds its value outside measurements; it changes only at grant.
- i_det_valid outside WAIT is ignored.
- Async reset at any point immediately forces reset values and abandons the measurement; no result is produced.

Test Plan:
- Single request: i_req=4'b0010; detector returns 100,101,102,103 in WAIT -> o_gnt=0010 one cycle after i_req; o_det_rstn low 8 cycles; o_res=101, o_res_id=1, o_res_timeout=0, o_res_valid until ready.
- Round-robin fairness: i_req=4'b1111 held, each grant followed by that bit dropping, ready tied high -> grant order 0,1,2,3; then with i_req=4'b1001 and pointer at 0 -> grants 0 then 3.
- Timeout: grant channel 2 and never pulse i_det_valid -> exactly SETTLE_CYC+TIMEOUT_CYC cycles after grant, o_res_valid=1, o_res_timeout=1, o_res=0, o_res_id=2.
- Backpressure and saturation: samples 1023 x4 with i_res_ready low 10 cycles -> o_res=1023 stable; no o_gnt despite a pending i_req=4'b0100; grant occurs 1 cycle after the cycle following acceptance.
- Ignored strobes: i_det_valid pulses during SETTLE with i_det_out=500, then 4 samples of 20 in WAIT -> o_res=20.
- Reset mid-WAIT: assert i_rst after 2 samples -> outputs go to 0 and o_det_rstn=0 without waiting for a clock edge; after release, a new request is granted normally with the pointer back at 0.
